// File: rtl/addsub_seq_ctrl.sv
// Sequencer for an external 4-bit adder/subtractor: add, sub and (with
// CALC_MUL_EN defined) a 4-cycle shift-add multiply; done lags DONE by one edge.
module addsub_seq_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] op,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [3:0] add_a,
  output logic [3:0] add_b,
  output logic       add_sel,
  input  logic [3:0] add_sum,
  input  logic       add_cout,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [7:0] result,
  output logic       cout
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t     r_state;
  logic [3:0] r_a;
  logic [3:0] r_b;
  logic       r_sub;
  logic       r_busy;
  logic       r_done;
  logic       r_err;
  logic [7:0] r_result;
  logic       r_cout;
  logic       w_valid;

`ifdef CALC_MUL_EN
  logic       r_mul;
  logic [3:0] r_acc_hi;
  logic [3:0] r_acc_lo;
  logic [1:0] r_cnt;

  assign w_valid = (op != 2'b11);
`else
  assign w_valid = ~op[1];
`endif

  assign busy   = r_busy;
  assign done   = r_done;
  assign err    = r_err;
  assign result = r_result;
  assign cout   = r_cout;

  always_comb begin
    add_a   = 4'h0;
    add_b   = 4'h0;
    add_sel = 1'b0;
    if (r_state == S_EXEC) begin
`ifdef CALC_MUL_EN
      if (r_mul) begin
        add_a = r_acc_hi;
        add_b = r_acc_lo[0] ? r_a : 4'h0;
      end else
`endif
      begin
        add_a   = r_a;
        add_b   = r_b;
        add_sel = r_sub;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_a      <= 4'h0;
      r_b      <= 4'h0;
      r_sub    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_result <= 8'h00;
      r_cout   <= 1'b0;
`ifdef CALC_MUL_EN
      r_mul    <= 1'b0;
      r_acc_hi <= 4'h0;
      r_acc_lo <= 4'h0;
      r_cnt    <= 2'd0;
`endif
    end else begin
      r_done <= (r_state == S_DONE);
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a    <= a;
            r_b    <= b;
            r_sub  <= op[0];
            r_busy <= 1'b1;
`ifdef CALC_MUL_EN
            r_mul    <= (op == 2'b10);
            r_acc_hi <= 4'h0;
            r_acc_lo <= b;
            r_cnt    <= 2'd0;
`endif
            // reserved ops skip EXEC and leave result/cout alone
            if (w_valid) begin
              r_err   <= 1'b0;
              r_state <= S_EXEC;
            end else begin
              r_err   <= 1'b1;
              r_state <= S_DONE;
            end
          end
        end
        S_EXEC: begin
`ifdef CALC_MUL_EN
          if (r_mul) begin
            {r_acc_hi, r_acc_lo} <= {add_cout, add_sum, r_acc_lo[3:1]};
            r_cnt <= r_cnt + 2'd1;
            if (r_cnt == 2'd3) begin
              r_result <= {add_cout, add_sum, r_acc_lo[3:1]};
              r_cout   <= 1'b0;
              r_state  <= S_DONE;
            end
          end else
`endif
          begin
            r_result <= {4'h0, add_sum};
            r_cout   <= add_cout;
            r_state  <= S_DONE;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_seq_ctrl.sv
// Scoreboard bench for addsub_seq_ctrl with a behavioural adder and
// an arithmetic reference model; honours CALC_MUL_EN.
module tb_addsub_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [1:0] op;
  logic [3:0] a, b;
  logic [3:0] add_a, add_b, add_sum;
  logic       add_sel, add_cout;
  logic       busy, done, err, cout;
  logic [7:0] result;
  logic [4:0] w_sum;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  typedef struct {
    logic [7:0] res;
    logic       c;
    logic       e;
    int         lat;
    int         due;
  } exp_t;

  exp_t q[$];

  logic [7:0] m_res  = 8'h00;
  logic       m_cout = 1'b0;
  logic       m_err  = 1'b0;

  addsub_seq_ctrl dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .op      (op),
    .a       (a),
    .b       (b),
    .add_a   (add_a),
    .add_b   (add_b),
    .add_sel (add_sel),
    .add_sum (add_sum),
    .add_cout(add_cout),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .result  (result),
    .cout    (cout)
  );

  assign w_sum = {1'b0, add_a} + {1'b0, add_b ^ {4{add_sel}}} + {4'h0, add_sel};
  assign add_sum  = w_sum[3:0];
  assign add_cout = w_sum[4];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t predict(input logic [3:0] ia, input logic [3:0] ib,
                                   input logic [1:0] iop);
    exp_t e;
    int   s;
    logic rsv;
    rsv = (iop == 2'b11);
`ifndef CALC_MUL_EN
    if (iop == 2'b10) rsv = 1'b1;
`endif
    e.lat = 2;
    if (rsv) begin
      m_err = 1'b1;
      e.lat = 1;
    end else if (iop == 2'b00) begin
      s = int'(ia) + int'(ib);
      m_res = 8'(s % 16);
      m_cout = (s > 15);
      m_err = 1'b0;
    end else if (iop == 2'b01) begin
      s = int'(ia) - int'(ib) + 16;
      m_res = 8'(s % 16);
      m_cout = (ia >= ib);
      m_err = 1'b0;
    end else begin
      m_res = 8'(int'(ia) * int'(ib));
      m_cout = 1'b0;
      m_err = 1'b0;
      e.lat = 5;
    end
    e.res = m_res;
    e.c   = m_cout;
    e.e   = m_err;
    e.due = 0;
    return e;
  endfunction

  // monitor: every done pulse must match the oldest outstanding request
  always @(negedge clk) begin
    exp_t e;
    if (done) begin
      if (q.size() == 0) begin
        chk("spurious_done", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        chk("result", 32'(result), 32'(e.res));
        chk("cout", 32'(cout), 32'(e.c));
        chk("err", 32'(err), 32'(e.e));
        chk("latency", cyc, e.due);
        chk("adder_idle", {add_a, add_b, add_sel}, 32'd0);
      end
    end
  end

  task automatic push_exp(input logic [3:0] ia, input logic [3:0] ib,
                          input logic [1:0] iop, input int acc_edge);
    exp_t e;
    e = predict(ia, ib, iop);
    e.due = acc_edge + e.lat;
    q.push_back(e);
  endtask

  task automatic drain();
    for (int i = 0; i < 30; i++) begin
      if (q.size() == 0) break;
      @(negedge clk);
      #1;
    end
    if (q.size() != 0) begin
      chk("drain_timeout", q.size(), 32'd0);
      q.delete();
    end
  endtask

  task automatic issue(input logic [3:0] ia, input logic [3:0] ib,
                       input logic [1:0] iop);
    @(negedge clk);
    a = ia;
    b = ib;
    op = iop;
    start = 1'b1;
    push_exp(ia, ib, iop, cyc + 1);
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
    drain();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_result"}, 32'(result), 32'd0);
    chk({tag, "_cout"}, 32'(cout), 32'd0);
    chk({tag, "_adder"}, {add_a, add_b, add_sel}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    op = 2'b00;
    a = 4'h0;
    b = 4'h0;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;

    issue(4'd7, 4'd5, 2'b00);
    issue(4'd9, 4'd9, 2'b00);
    issue(4'd3, 4'd5, 2'b01);
    issue(4'd5, 4'd3, 2'b01);
    issue(4'd15, 4'd15, 2'b10);
    issue(4'd0, 4'd9, 2'b10);
    issue(4'd6, 4'd2, 2'b00);
    issue(4'd1, 4'd1, 2'b11);
    issue(4'd4, 4'd4, 2'b01);

    // starts while busy carry new operands and must be ignored
    @(negedge clk);
    a = 4'd7; b = 4'd5; op = 2'b00; start = 1'b1;
    push_exp(4'd7, 4'd5, 2'b00, cyc + 1);
    @(negedge clk);
    a = 4'd1; b = 4'd1;
    @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    drain();
    repeat (3) @(negedge clk);

    // start held high: second op taken on the IDLE cycle after DONE
    @(negedge clk);
    a = 4'd2; b = 4'd3; op = 2'b00; start = 1'b1;
    push_exp(4'd2, 4'd3, 2'b00, cyc + 1);
    push_exp(4'd9, 4'd9, 2'b00, cyc + 4);
    repeat (3) @(negedge clk);
    a = 4'd9; b = 4'd9;
    @(negedge clk);
    start = 1'b0;
    drain();

    // reset mid-operation, with start held through reset
    @(negedge clk);
    a = 4'd13; b = 4'd11; op = 2'b10; start = 1'b1;
    @(negedge clk);
`ifdef CALC_MUL_EN
    @(negedge clk);
`else
    op = 2'b01;
`endif
    rst = 1'b1;
    @(negedge clk);
    chk_zero("abort");
    @(negedge clk);
    chk_zero("rst_prio");
    rst = 1'b0;
    start = 1'b0;
    m_res = 8'h00;
    m_cout = 1'b0;
    m_err = 1'b0;
    repeat (8) @(negedge clk);

    for (int i = 0; i < 40; i++)
      issue(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            2'($urandom_range(0, 3)));

    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
